// File: rtl/debounce_pkg.sv
// debounce_pkg: default sizing constants and a counter-width helper for the button debounce bank.
package debounce_pkg;

   localparam int DEFAULT_SAMPLE_TIME  = 5000;
   localparam int DEFAULT_CNT_W        = 22;
   localparam int DEFAULT_REPEAT_DELAY = 50000000;
   localparam int DEFAULT_REPEAT_RATE  = 10000000;

   // Bits needed to hold values 0..n-1; never less than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((64'd1 << w) < 64'(n)) w++;
      return w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button's synchroniser, stable-time counter, debounced level and press/release pulses.
// The repeat counter exists only when AUTO_REPEAT_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int SAMPLE_TIME  = DEFAULT_SAMPLE_TIME,
`ifdef AUTO_REPEAT_EN
   parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE,
`endif
   parameter int CNT_W        = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic level,
   output logic press,
   output logic release_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_TIME - 1);

   logic             sync1;
   logic             s;
   logic             level_d;
   logic [CNT_W-1:0] cnt;
   logic             rep;

`ifdef AUTO_REPEAT_EN
   localparam int RC_W = clog2(REPEAT_DELAY);

   logic [RC_W-1:0] rc;
   logic            held;

   // Counting starts in the cycle of the first press pulse so the first repeat lands REPEAT_DELAY later.
   assign held = level & level_d;
   assign rep  = held && (rc == RC_W'(REPEAT_DELAY - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc <= '0;
      end else if (!held) begin
         rc <= '0;
      end else if (rep) begin
         rc <= RC_W'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
         rc <= rc + 1'b1;
      end
   end
`else
   assign rep = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1         <= 1'b0;
         s             <= 1'b0;
         cnt           <= '0;
         level         <= 1'b0;
         level_d       <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync1 <= button;
         s     <= sync1;
         if (s == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= s;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         level_d       <= level;
         press         <= (level & ~level_d) | rep;
         release_pulse <= ~level & level_d;
      end
   end

endmodule

// File: rtl/button_debounce_bank.sv
// button_debounce_bank: multi-channel push-button conditioner; channel 0 also yields the manual CPU clock.
// Optional AUTO_REPEAT_EN adds held-key repeat pulses on Key_press.
module button_debounce_bank
   import debounce_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int SAMPLE_TIME  = DEFAULT_SAMPLE_TIME,
   parameter int CNT_W        = DEFAULT_CNT_W,
   parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
   input  logic                BasysCLK,
   input  logic                Reset,
   input  logic [CHANNELS-1:0] Button,
   output logic [CHANNELS-1:0] Key_level,
   output logic [CHANNELS-1:0] Key_press,
   output logic [CHANNELS-1:0] Key_release,
   output logic                CPUCLK
);

   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("button_debounce_bank: CHANNELS must be 1..16");
   end
   if (SAMPLE_TIME < 2) begin : g_bad_sample_time
      $error("button_debounce_bank: SAMPLE_TIME must be >= 2");
   end
   if (CNT_W < 1 || (CNT_W < 31 && (1 << CNT_W) <= SAMPLE_TIME)) begin : g_bad_cnt_w
      $error("button_debounce_bank: CNT_W too narrow for SAMPLE_TIME");
   end
   if (REPEAT_DELAY < 2 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
      $error("button_debounce_bank: need REPEAT_DELAY >= 2 and 1 <= REPEAT_RATE <= REPEAT_DELAY");
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      debounce_channel #(
         .SAMPLE_TIME  (SAMPLE_TIME),
`ifdef AUTO_REPEAT_EN
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE),
`endif
         .CNT_W        (CNT_W)
      ) u_chan (
         .clk           (BasysCLK),
         .rst_n         (Reset),
         .button        (Button[g]),
         .level         (Key_level[g]),
         .press         (Key_press[g]),
         .release_pulse (Key_release[g])
      );
   end

   // Inverter on a flop output: glitch-free, idles high, and rises at the debounced release.
   assign CPUCLK = ~Key_level[0];

endmodule
